// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: multiplier FSM state encoding and default operand width.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int ARITH_N = 8;

endpackage

// File: rtl/seq_ripple_adder.sv
// N-bit ripple-carry adder from full-adder cells; true carry-out.
module seq_ripple_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = c[N];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Iterative unsigned shift-add multiplier, one add+shift per cycle over a shared ripple adder.
// Optional MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module shift_add_mult_ctrl
    import arith_pkg::*;
#(
    parameter  int N     = ARITH_N,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   op_a,
    input  logic [N-1:0]   op_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    mult_state_t      state_q, state_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N-1:0]     acc_hi_q, acc_hi_d;
    logic [N-1:0]     acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   product_q, product_d;

    logic [N-1:0]     add_b, add_sum;
    logic             add_cout;
    logic [2*N:0]     full_acc;

    assign add_b = acc_lo_q[0] ? mcand_q : '0;

    seq_ripple_adder #(.N(N)) u_adder (
        .a_i    (acc_hi_q),
        .b_i    (add_b),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Carry sits above the sum so it lands in bit N-1 of acc_hi after the shift.
    assign full_acc = {add_cout, add_sum, acc_lo_q};

`ifdef MULT_EARLY_TERM_EN
    logic [N:0]   ones_mask;
    logic [N-1:0] rem_mask;
    logic [2*N:0] full_sh;

    // Multiplier bits still to come after this cycle live in acc_lo[cnt-1:1].
    assign ones_mask = ({{N{1'b0}}, 1'b1} << cnt_q) - {{N{1'b0}}, 1'b1};
    assign rem_mask  = ones_mask[N-1:0] & ~{{(N-1){1'b0}}, 1'b1};
    assign full_sh   = full_acc >> cnt_q;
`endif

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mcand_d  = op_a;
                    acc_hi_d = '0;
                    acc_lo_d = op_b;
                    cnt_d    = CNT_W'(N);
                    state_d  = RUN;
                end
            end
            RUN: begin
                {acc_hi_d, acc_lo_d} = full_acc[2*N:1];
                cnt_d = cnt_q - CNT_W'(1);
`ifdef MULT_EARLY_TERM_EN
                if ((acc_lo_q & rem_mask) == '0) begin
                    {acc_hi_d, acc_lo_d} = full_sh[2*N-1:0];
                    cnt_d     = '0;
                    product_d = full_sh[2*N-1:0];
                    state_d   = DONE;
                end
`else
                if (cnt_q == CNT_W'(1)) begin
                    product_d = full_acc[2*N:1];
                    state_d   = DONE;
                end
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl (N=8): vector table plus handshake/reset corner sequences.
module tb_shift_add_mult_ctrl;

    localparam int NB = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [NB-1:0]   op_a = '0;
    logic [NB-1:0]   op_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [2*NB-1:0] product;
    logic            busy;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    shift_add_mult_ctrl #(.N(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0]   a;
        logic [NB-1:0]   b;
        logic [2*NB-1:0] p;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Edges after the accept edge until out_valid is seen.
    function automatic int exp_lat(input logic [NB-1:0] b);
`ifdef MULT_EARLY_TERM_EN
        int k = 1;
        for (int i = 0; i < NB; i++) if (b[i]) k = i + 1;
        return k;
`else
        return NB;
`endif
    endfunction

    // Present operands at a negedge and return just after the accept edge.
    task automatic accept(input logic [NB-1:0] a, input logic [NB-1:0] b, input string nm);
        int t;
        @(negedge clk);
        op_a = a; op_b = b; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk({nm, " in_ready timeout"}, 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit run_ok);
        lat = 0;
        run_ok = 1'b1;
        forever begin
            @(negedge clk);
            if (out_valid || lat >= 100) break;
            if (in_ready || !busy) run_ok = 1'b0;
            lat++;
        end
    endtask

    task automatic run_op(input logic [NB-1:0] a, input logic [NB-1:0] b,
                          input logic [2*NB-1:0] p, input string nm);
        int lat;
        bit ok;
        accept(a, b, nm);
        wait_done(lat, ok);
        chk({nm, " product"}, 32'(product), 32'(p));
        chk({nm, " latency"}, lat, exp_lat(b));
        chk({nm, " run in_ready=0/busy=1"}, 32'(ok), 1);
        chk({nm, " done in_ready"}, 32'(in_ready), 0);
        @(negedge clk);
        chk({nm, " back to idle"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int lat;
        bit ok;
        bit stable;

        tbl[0] = '{8'd3,   8'd5,   16'd15};
        tbl[1] = '{8'd255, 8'd255, 16'd65025};
        tbl[2] = '{8'h5A,  8'd0,   16'd0};
        tbl[3] = '{8'd0,   8'h77,  16'd0};
        tbl[4] = '{8'd12,  8'd11,  16'd132};
        tbl[5] = '{8'd200, 8'd3,   16'd600};
        tbl[6] = '{8'd1,   8'd255, 16'd255};
        tbl[7] = '{8'd128, 8'd128, 16'd16384};
        tbl[8] = '{8'd255, 8'd1,   16'd255};
        tbl[9] = '{8'd17,  8'd129, 16'd2193};

        // Reset state
        #12;
        chk("reset in_ready", 32'(in_ready), 1);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset product", 32'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].p, $sformatf("vec%0d", i));

        // Backpressure: DONE held 20 cycles; a new request in that window is dropped.
        out_ready = 1'b0;
        accept(8'd6, 8'd7, "bp");
        wait_done(lat, ok);
        chk("bp product", 32'(product), 42);
        stable = 1'b1;
        op_a = 8'd9; op_b = 8'd9; in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (product !== 16'd42 || !out_valid || in_ready || !busy) stable = 1'b0;
        end
        chk("bp hold stable", 32'(stable), 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp release idle", {29'd0, out_valid, in_ready, busy}, 32'b010);
        @(negedge clk);
        chk("bp no queued op", 32'(busy), 0);

        // Asynchronous reset in the middle of RUN
        accept(8'd200, 8'd200, "rst_run");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst mid-run flags", {29'd0, out_valid, busy, in_ready}, 32'b001);
        #1 rst_n = 1'b1;
        run_op(8'd7, 8'd9, 16'd63, "after_rst");

        // Asynchronous reset while holding a result in DONE
        out_ready = 1'b0;
        accept(8'd10, 8'd10, "rst_done");
        wait_done(lat, ok);
        chk("rst_done product", 32'(product), 100);
        #2 rst_n = 1'b0;
        #1;
        chk("rst in done drops out_valid", {30'd0, out_valid, in_ready}, 32'b01);
        chk("rst in done clears product", 32'(product), 0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        // Back-to-back with in_valid held high across both operations
        @(negedge clk);
        op_a = 8'd12; op_b = 8'd11; in_valid = 1'b1;
        @(posedge clk);
        #1 op_a = 8'd200; op_b = 8'd3;
        wait_done(lat, ok);
        chk("b2b first product", 32'(product), 132);
        chk("b2b first in_ready low", 32'(ok), 1);
        @(negedge clk);
        chk("b2b idle between", 32'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done(lat, ok);
        chk("b2b second product", 32'(product), 600);
        chk("b2b second latency", lat, exp_lat(8'd3));

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
